// File: rtl/sha256_msg_padder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_padder_if
//  Description : Handshake bundle between a message source/sink and the
//                SHA-256 message padder.
//                Input side : in_valid / in_ready / in_data / in_last /
//                             in_nbytes  (big-endian word stream)
//                Output side: out_valid / out_ready / out_word / out_idx /
//                             out_last   (padded block words)
//                slave  modport : the padder
//                master modport : the environment feeding and draining it
//  Revision    : 1.0 - initial release
// ============================================================================
interface sha256_msg_padder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_nbytes;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [3:0]  out_idx;
    logic        out_last;

    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, out_ready,
        output in_ready, out_valid, out_word, out_idx, out_last
    );

    modport master (
        output in_valid, in_data, in_last, in_nbytes, out_ready,
        input  in_ready, out_valid, out_word, out_idx, out_last
    );
endinterface
`default_nettype wire

// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_msg_padder
//  Description : Turns a byte-aligned big-endian message word stream into
//                complete FIPS 180-4 padded 512-bit blocks, one word per
//                beat, tagged with the in-block word index 0..15.
//  Ports       : clk      - clock, rising edge
//                reset_n  - asynchronous active-low reset
//                clear    - synchronous abort back to IDLE
//                bus      - sha256_msg_padder_if.slave (input/output streams)
//  Parameters  : LEN_W    - bit-length counter width (16..64)
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    input  wire logic           clear,
    sha256_msg_padder_if.slave  bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_PADW = 3'd2;
    localparam logic [2:0] S_ZERO = 3'd3;
    localparam logic [2:0] S_LENH = 3'd4;
    localparam logic [2:0] S_LENL = 3'd5;

    logic [2:0]       r_state;
    logic [3:0]       r_idx;
    logic [LEN_W-1:0] r_cnt;
    // Low for the first cycle after reset/clear so in_ready/out_valid start at 0.
    logic             r_live;

    logic [2:0]       w_nbytes;
    logic [5:0]       w_inc;
    logic [31:0]      w_merged;
    logic [63:0]      w_cnt64;
    logic [3:0]       w_next_idx;
    logic             w_in_fire;
    logic             w_out_fire;

    // Byte count of the current word: 0 on in_nbytes encodes a full word.
    assign w_nbytes   = (bus.in_nbytes == 2'd0) ? 3'd4 : {1'b0, bus.in_nbytes};
    assign w_inc      = bus.in_last ? {w_nbytes, 3'b000} : 6'd32;
    assign w_next_idx = r_idx + 4'd1;
    assign w_in_fire  = bus.in_valid & bus.in_ready;
    assign w_out_fire = bus.out_valid & bus.out_ready;
    assign bus.out_idx = r_idx;

    generate
        if (LEN_W < 64) begin : g_cnt_pad
            assign w_cnt64 = {{(64-LEN_W){1'b0}}, r_cnt};
        end else begin : g_cnt_full
            assign w_cnt64 = r_cnt;
        end
    endgenerate

    // Final partial word: keep the valid leading bytes, append 0x80, zero the rest.
    always_comb begin
        w_merged = bus.in_data;
        if (bus.in_last) begin
            case (bus.in_nbytes)
                2'd1:    w_merged = {bus.in_data[31:24], 8'h80, 16'h0000};
                2'd2:    w_merged = {bus.in_data[31:16], 8'h80, 8'h00};
                2'd3:    w_merged = {bus.in_data[31:8],  8'h80};
                default: w_merged = bus.in_data;
            endcase
        end
    end

    // Output side. clear suppresses both handshakes so an abort never
    // coincides with a word being consumed on either side.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_word  = 32'h0000_0000;
        bus.out_last  = 1'b0;
        case (r_state)
            S_IDLE, S_DATA: begin
                bus.in_ready  = bus.out_ready & r_live & ~clear;
                bus.out_valid = bus.in_valid  & r_live & ~clear;
                bus.out_word  = r_live ? w_merged : 32'h0000_0000;
            end
            S_PADW: begin
                bus.out_valid = ~clear;
                bus.out_word  = 32'h8000_0000;
            end
            S_ZERO: begin
                bus.out_valid = ~clear;
            end
            S_LENH: begin
                bus.out_valid = ~clear;
                bus.out_word  = w_cnt64[63:32];
            end
            S_LENL: begin
                bus.out_valid = ~clear;
                bus.out_word  = w_cnt64[31:0];
                bus.out_last  = 1'b1;
            end
            default: begin
                bus.out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_live  <= 1'b0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_out_fire) begin
                r_idx <= w_next_idx;
            end
            case (r_state)
                S_IDLE, S_DATA: begin
                    // Pass-through: an input transfer is also an output transfer.
                    if (w_in_fire) begin
                        r_cnt <= r_cnt + {{(LEN_W-6){1'b0}}, w_inc};
                        if (!bus.in_last) begin
                            r_state <= S_DATA;
                        end else if (bus.in_nbytes == 2'd0) begin
                            r_state <= S_PADW;
                        end else begin
                            r_state <= (w_next_idx == 4'd14) ? S_LENH : S_ZERO;
                        end
                    end
                end
                S_PADW: begin
                    if (w_out_fire) begin
                        r_state <= (w_next_idx == 4'd14) ? S_LENH : S_ZERO;
                    end
                end
                S_ZERO: begin
                    // Zeros run until index 13 has gone out; a pad landing at
                    // 14/15 therefore spills naturally into a fresh block.
                    if (w_out_fire && (r_idx == 4'd13)) begin
                        r_state <= S_LENH;
                    end
                end
                S_LENH: begin
                    if (w_out_fire) begin
                        r_state <= S_LENL;
                    end
                end
                S_LENL: begin
                    if (w_out_fire) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
